// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use stalls, EX-resolved branch
// flushes, and multi-cycle data-memory freezes, with saturating perf counters.
module pipeline_hazard_controller #(
   parameter int reg_addr_bits = 5,
   parameter int count_bits    = 16,
   parameter int mem_timeout   = 64
) (
   input  logic                     clk,
   input  logic                     n_reset,
   input  logic [reg_addr_bits-1:0] id_rs1,
   input  logic [reg_addr_bits-1:0] id_rs2,
   input  logic                     id_uses_rs1,
   input  logic                     id_uses_rs2,
   input  logic                     ex_mem_read,
   input  logic [reg_addr_bits-1:0] ex_rd,
   input  logic                     ex_branch_taken,
   input  logic                     mem_req,
   input  logic                     mem_ready,
   output logic                     pc_write_en,
   output logic                     if_id_write_en,
   output logic                     if_id_flush,
   output logic                     id_ex_flush,
   output logic                     ex_mem_write_en,
   output logic                     mem_wb_bubble,
   output logic [count_bits-1:0]    stall_count,
   output logic [count_bits-1:0]    flush_count,
   output logic                     mem_error
);

   localparam int WB = $clog2(mem_timeout + 1);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t          state, state_nxt;
   logic [WB-1:0]   wait_cnt, wait_nxt;
   logic            load_use, freeze, stall_inc, flush_inc, err_set;

   // A dropped mem_req while waiting is tolerated as completion, so the freeze
   // condition is the same in both states.
   assign freeze   = mem_req & ~mem_ready;
   assign load_use = ex_mem_read & (ex_rd != '0) &
                     ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
   assign err_set  = freeze & (wait_nxt == WB'(mem_timeout));

   always_comb begin
      pc_write_en     = 1'b1;
      if_id_write_en  = 1'b1;
      if_id_flush     = 1'b0;
      id_ex_flush     = 1'b0;
      ex_mem_write_en = 1'b1;
      mem_wb_bubble   = 1'b0;
      state_nxt       = RUN;
      wait_nxt        = '0;
      stall_inc       = 1'b0;
      flush_inc       = 1'b0;
      if (freeze) begin
         pc_write_en     = 1'b0;
         if_id_write_en  = 1'b0;
         ex_mem_write_en = 1'b0;
         mem_wb_bubble   = 1'b1;
         stall_inc       = 1'b1;
         state_nxt       = MEM_WAIT;
         if (state == RUN)
            wait_nxt = WB'(1);
         else if (wait_cnt == WB'(mem_timeout))
            wait_nxt = wait_cnt;
         else
            wait_nxt = wait_cnt + WB'(1);
      end else if (ex_branch_taken) begin
         // the ID instruction is flushed, so a coincident load-use is moot
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         flush_inc   = 1'b1;
      end else if (load_use) begin
         pc_write_en    = 1'b0;
         if_id_write_en = 1'b0;
         id_ex_flush    = 1'b1;
         stall_inc      = 1'b1;
      end
      if (!n_reset) begin
         pc_write_en     = 1'b0;
         if_id_write_en  = 1'b0;
         ex_mem_write_en = 1'b0;
         if_id_flush     = 1'b1;
         id_ex_flush     = 1'b1;
         mem_wb_bubble   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state       <= RUN;
         wait_cnt    <= '0;
         stall_count <= '0;
         flush_count <= '0;
         mem_error   <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (stall_inc && stall_count != '1)
            stall_count <= stall_count + count_bits'(1);
         if (flush_inc && flush_count != '1)
            flush_count <= flush_count + count_bits'(1);
         if (err_set)
            mem_error <= 1'b1;
      end
   end

endmodule
